// File: rtl/asyn_pkg.sv
// Shared definitions for the req/ack handshake server.
// Holds the FSM state encoding, the LFSR feedback taps, the default seed and
// small helper functions used by req_server.
package asyn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAckHi,
        StAckLo
    } state_e;

    localparam logic [31:0] LfsrTaps    = 32'h0040_0007;
    localparam logic [31:0] DefaultSeed = 32'h0000_0001;

    // One Galois-style step: shift left, fold taps back in when the MSB falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? LfsrTaps : 32'h0000_0000);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    function automatic logic [31:0] effective_seed(input logic [31:0] seed);
        return (seed == 32'h0000_0000) ? DefaultSeed : seed;
    endfunction

endpackage

// File: rtl/req_sync.sv
// Multi-flop synchronizer for the asynchronous req input.
// Ports:
//   clk  - sampling clock
//   rst  - asynchronous active-high reset, clears the whole chain
//   d    - asynchronous input
//   q    - synchronized output (last flop of the chain)
module req_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/req_server.sv
// 4-phase req/ack handshake server.
// A client raises req; after synchronization and RESP_DELAY wait cycles the
// server raises ack and presents an LFSR word on data_out together with a
// running checksum of all words served. When req drops, ack drops, the LFSR
// advances and the completed-handshake counter increments.
// Ports:
//   clk           - rising-edge clock
//   rst           - asynchronous active-high reset
//   req           - client request, asynchronous to clk
//   ack           - registered acknowledge
//   data_out      - current LFSR word, stable while ack=1
//   data_test_out - modulo-2^32 sum of all words served, stable while ack=1
//   txn_count     - completed handshakes, wraps silently
//   busy          - high whenever the FSM is not idle
module req_server
    import asyn_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RESP_DELAY  = 3,
    parameter logic [31:0] DATA_SEED   = DefaultSeed
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        ack,
    output logic [31:0] data_out,
    output logic [31:0] data_test_out,
    output logic [15:0] txn_count,
    output logic        busy
);

    localparam logic [31:0] SeedEff   = effective_seed(DATA_SEED);
    localparam logic [3:0]  DelayLoad = (RESP_DELAY == 0) ? 4'd0 : 4'(RESP_DELAY - 1);

    logic        req_s;
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] sum_q, sum_d;
    logic [15:0] txn_count_q, txn_count_d;

    req_sync #(
        .STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk(clk),
        .rst(rst),
        .d  (req),
        .q  (req_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            ack_q       <= 1'b0;
            lfsr_q      <= SeedEff;
            sum_q       <= 32'h0000_0000;
            txn_count_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            lfsr_q      <= lfsr_d;
            sum_q       <= sum_d;
            txn_count_q <= txn_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        sum_d       = sum_q;
        txn_count_d = txn_count_q;

        unique case (state_q)
            StIdle: begin
                if (req_s) begin
                    if (RESP_DELAY == 0) begin
                        state_d = StAckHi;
                        sum_d   = sum_q + lfsr_q;
                    end else begin
                        state_d = StWait;
                        cnt_d   = DelayLoad;
                    end
                end
            end
            StWait: begin
                // Abort takes priority over the delay expiring.
                if (!req_s) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAckHi;
                    sum_d   = sum_q + lfsr_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAckHi: begin
                if (!req_s) begin
                    state_d = StAckLo;
                end
            end
            StAckLo: begin
                lfsr_d      = lfsr_step(lfsr_q);
                txn_count_d = txn_count_q + 16'd1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        ack_d = (state_d == StAckHi);
    end

    assign ack           = ack_q;
    assign data_out      = lfsr_q;
    assign data_test_out = sum_q;
    assign txn_count     = txn_count_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: doc/req_server.md
REQ_SERVER -- requirements
Module: req_server

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the req synchronizer depth (legal 2..4).
REQ-002 Parameter RESP_DELAY, default 3, SHALL set the number of wait cycles between synchronized req high and ack rise (legal 0..15).
REQ-003 Parameter DATA_SEED, default 32'h0000_0001, SHALL set the LFSR reset value; a zero seed SHALL be replaced by 32'h0000_0001.
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  1  request from the client, asynchronous to clk, 4-phase protocol.
REQ-007 ack  output  1  acknowledge to the client, registered.
REQ-008 data_out  output  32  response word, valid and stable while ack=1.
REQ-009 data_test_out  output  32  running checksum, valid and stable while ack=1.
REQ-010 txn_count  output  16  count of completed handshakes.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 req SHALL pass through a SYNC_STAGES-deep flop chain; only the chain output req_s SHALL be used internally.
REQ-013 FSM states SHALL be IDLE, WAIT, ACK_HI, ACK_LO.
REQ-014 IDLE: req_s=1 -> WAIT with delay counter loaded to RESP_DELAY-1, or -> ACK_HI directly when RESP_DELAY=0.
REQ-015 WAIT: counter decrements each cycle; at 0 with req_s=1 -> ACK_HI.
REQ-016 WAIT: req_s=0 on any cycle -> IDLE (abort); no ack, no LFSR advance, no count change.
REQ-017 ACK_HI: ack=1; remains until req_s=0, then -> ACK_LO.
REQ-018 ACK_LO: ack=0, LFSR advances one step, txn_count increments, -> IDLE; one cycle only.
REQ-019 ack SHALL rise on edge SYNC_STAGES+RESP_DELAY+1, with edge 1 being the first edge to sample req=1 (req held high throughout).
REQ-020 IDLE with req_s still 1 after ACK_LO (client protocol violation) SHALL start a new handshake normally.
REQ-021 LFSR step: next = {x[30:0],1'b0} XOR (x[31] ? 32'h0040_0007 : 0); data_out = current LFSR value.
REQ-022 data_test_out SHALL equal the modulo-2^32 sum of every data_out value presented with ack=1, including the current one; update occurs on entry to ACK_HI.
REQ-023 data_out and data_test_out SHALL NOT change while ack=1.
REQ-024 txn_count SHALL wrap 16'hFFFF -> 16'h0000 without a flag.

Reset
REQ-025 rst=1 SHALL immediately, independent of clk, force: state IDLE, ack=0, busy=0, sync chain all 0, delay counter 0, LFSR=effective seed, data_test_out=0, txn_count=0.
REQ-026 Reset during WAIT/ACK_HI/ACK_LO SHALL drop ack at once; the interrupted handshake SHALL NOT count.
REQ-027 After rst falls, the first handshake SHALL require req to be sampled through the full synchronizer again.

Structure
REQ-028 Shared package asyn_pkg SHALL hold the FSM state enum, the LFSR tap constant 32'h0040_0007, and the default seed.
REQ-029 The synchronizer SHALL be a separate sub-module req_sync (parameter STAGES, ports clk, rst, d, q); all else in req_server.

Verification
REQ-030 Defaults, req held high from edge 1 -> ack=1 at edge 6, data_out=32'h1, data_test_out=32'h1; drop req -> ack=0 two cycles after ACK_LO entry sequence, txn_count=1.
REQ-031 Second handshake -> data_out=32'h2, data_test_out=32'h3, txn_count=2; third -> data_out=32'h4, data_test_out=32'h7.
REQ-032 req pulse of 3 cycles (drops during WAIT) -> ack never rises, txn_count=0, next handshake still returns data_out=32'h1.
REQ-033 rst asserted while ack=1 -> ack=0 before next clk edge, txn_count=0, data_test_out=0, next handshake returns seed.
REQ-034 RESP_DELAY=0, SYNC_STAGES=3 -> ack rises at edge 4; DATA_SEED=0 -> first data_out=32'h1.
REQ-035 Preload 65535 handshakes (or force count to 16'hFFFF) then one handshake -> txn_count=16'h0000, handshake otherwise normal.
